// File: rtl/wb_mem_arbiter.sv
// wb_mem_arbiter: round-robin arbiter connecting NUM_MASTERS Wishbone masters
// to a single memory controller with a read/write strobe and a one-cycle
// response pulse. Transfers follow the sequence IDLE -> BUSY -> ACK -> IDLE.
// Optional feature macro: WB_TIMEOUT_EN. When it is defined, a BUSY watchdog
// with a limit of TIMEOUT_CYCLES ends a stalled transfer with m_err_o.
module wb_mem_arbiter #(
  parameter int unsigned NUM_MASTERS    = 2,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_MASTERS-1:0]           m_cyc_i,
  input  logic [NUM_MASTERS-1:0]           m_stb_i,
  input  logic [NUM_MASTERS-1:0]           m_we_i,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr_i,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_data_i,
  output logic [NUM_MASTERS-1:0]           m_ack_o,
  output logic [NUM_MASTERS-1:0]           m_err_o,
  output logic [DATA_WIDTH-1:0]            m_data_o,
  output logic                             mem_read_o,
  output logic                             mem_write_o,
  output logic [ADDR_WIDTH-1:0]            mem_addr_o,
  output logic [DATA_WIDTH-1:0]            mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]            mem_rdata_i,
  input  logic                             mem_response_i
);

  localparam int unsigned PTR_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  if (NUM_MASTERS == 0 || NUM_MASTERS > 8 || TIMEOUT_CYCLES == 0) begin : g_param_check
    $error("wb_mem_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_ACK
  } state_t;

  state_t                 state;
  logic [PTR_W-1:0]       ptr;
  logic [PTR_W-1:0]       grant;
  logic [PTR_W-1:0]       pick;
  logic [PTR_W-1:0]       idx;
  logic                   found;
  logic                   any_req;
  logic [NUM_MASTERS-1:0] req;
  logic [NUM_MASTERS-1:0] grant_oh;
  logic                   tmo_hit;

  assign grant_oh = NUM_MASTERS'(1) << grant;

  // Round-robin pick: first requesting master at or after ptr, wrapping.
  always_comb begin
    req     = m_cyc_i & m_stb_i;
    any_req = |req;
    pick    = '0;
    found   = 1'b0;
    idx     = '0;
    for (int unsigned off = 0; off < NUM_MASTERS; off++) begin
      idx = PTR_W'((32'(ptr) + off) % NUM_MASTERS);
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

`ifdef WB_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0]       tmo_cnt;
  logic [NUM_MASTERS-1:0] err_q;

  // The limit is reached in the BUSY cycle whose count equals TIMEOUT_CYCLES-1.
  assign tmo_hit = (state == ST_BUSY) && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
  assign m_err_o = err_q;

  // Count BUSY cycles that end without a response; cleared outside BUSY.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
    end else if (state == ST_BUSY && !mem_response_i && !tmo_hit) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end else begin
      tmo_cnt <= '0;
    end
  end

  // One-cycle error pulse on timeout; a same-cycle response takes priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= '0;
    end else if (tmo_hit && !mem_response_i) begin
      err_q <= grant_oh & m_cyc_i;
    end else begin
      err_q <= '0;
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign m_err_o = '0;
`endif

  // Transfer sequencer with registered strobes, ack and read data.
  // ST_ACK is also the closing cycle after a timeout (ack stays low there).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      ptr         <= '0;
      grant       <= '0;
      mem_read_o  <= 1'b0;
      mem_write_o <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      m_ack_o     <= '0;
      m_data_o    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            grant       <= pick;
            mem_addr_o  <= m_addr_i[pick*ADDR_WIDTH +: ADDR_WIDTH];
            mem_wdata_o <= m_data_i[pick*DATA_WIDTH +: DATA_WIDTH];
            mem_read_o  <= !m_we_i[pick];
            mem_write_o <= m_we_i[pick];
            state       <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (mem_response_i) begin
            m_data_o    <= mem_rdata_i;
            m_ack_o     <= grant_oh & m_cyc_i;
            mem_read_o  <= 1'b0;
            mem_write_o <= 1'b0;
            state       <= ST_ACK;
          end else if (tmo_hit) begin
            mem_read_o  <= 1'b0;
            mem_write_o <= 1'b0;
            state       <= ST_ACK;
          end
        end
        ST_ACK: begin
          m_ack_o <= '0;
          ptr     <= (grant == PTR_W'(NUM_MASTERS - 1)) ? '0 : grant + 1'b1;
          state   <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
